frame_assembler: RTL and testbench
==================================

Name: frame_assembler

Overview:
- Upstream neighbour of the max-pool stage.
- Accepts a row-major 8-bit pixel stream over a valid/ready handshake and assembles it into a registered N*N frame.
- Presents the frame as a stable parallel bus plus frame_valid, holds it until the downstream stage acknowledges, then refills.
- Back-pressures the source while a full frame is held.

Parameters:
- N, 32, image side length in pixels (frame is N*N); N >= 2.
- PW, 8, pixel width in bits; 8 for the max-pool datapath.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- pix_in  input  PW  incoming pixel, row-major order (row 0 col 0 first)
- pix_valid  input  1  pix_in valid this cycle
- pix_sof  input  1  start-of-frame marker, qualified by pix_valid; used only with IMG_SOF_CHECK_EN
- pix_ready  output  1  block can accept a pixel this cycle
- image_out  output  [N-1:0][N-1:0][PW-1:0]  assembled frame; image_out[r][c] = pixel at row r, column c
- frame_valid  output  1  image_out holds a complete frame
- frame_ack  input  1  downstream has consumed the frame
- pix_count  output  $clog2(N*N+1)  pixels accepted into the current frame
- sof_err  output  1  sticky SOF misalignment flag; tied 0 without IMG_SOF_CHECK_EN

Behaviour:
- Reset is synchronous and active-high. When rst is high at a rising clk edge:
  - state=FILL, row=0, col=0, pix_count=0;
  - frame_valid=0, sof_err=0;
  - every image_out element = 0.
- Reset mid-fill or mid-hold discards the partial or held frame; the frame restarts from pixel 0 on the next cycle.
- States: FILL, FULL. pix_ready = (state==FILL); it is derived from registered state only, with no combinational path from pix_valid.
- FILL: a transfer occurs when pix_valid && pix_ready.
  - On a transfer, image_out[row][col] <= pix_in and pix_count increments.
  - col increments; at col==N-1 it wraps to 0 and row increments.
  - A transfer at row==N-1, col==N-1 (the last pixel) moves state to FULL and sets frame_valid=1 on the same edge. frame_valid is therefore visible the cycle after the last pixel is accepted.
  - pix_count reads N*N in FULL.
  - Gaps (pix_valid low) stall the fill with no state change.
- FULL:
  - pix_ready=0; image_out and pix_count are held bit-stable; pix_valid is ignored.
  - frame_ack high at the edge: next state=FILL, frame_valid=0, row/col/pix_count=0. image_out is not cleared; each element is overwritten as new pixels arrive.
  - frame_ack may be high in the first FULL cycle, giving a minimum hold of one cycle.
- frame_ack in FILL is ignored.
- Throughput: N*N accepted pixels + at least 1 hold cycle per frame. A pixel offered in the ack cycle is not accepted (pix_ready=0 that cycle); it is accepted the following cycle.
- No arithmetic beyond counters. Counters never exceed N-1 (row/col) or N*N (pix_count).

Optional Feature:
Macro IMG_SOF_CHECK_EN.
- Defined:
  - In FILL, a transfer with pix_sof=1 is always stored as pixel (0,0): the pixel is written to image_out[0][0], row=0, col=1, pix_count=1, and any partial frame is discarded.
  - If pix_count != 0 when that SOF transfer occurs, sof_err is set.
  - A transfer with pix_sof=0 while pix_count==0 also sets sof_err; the pixel is still stored at (0,0).
  - sof_err is cleared only by rst.
- Not defined: pix_sof is ignored, sof_err is constant 0, and fill order is purely positional.

Test Plan:
- N=4, reset then stream 16 pixels 0x01..0x10 with pix_valid constantly high -> frame_valid rises the cycle after pixel 16; image_out[0][0]=0x01, [1][0]=0x05, [3][3]=0x10; pix_count=16; pix_ready=0.
- Hold frame 5 cycles with frame_ack=0 while pix_valid=1, pix_in=0xFF -> image_out unchanged, no transfers; ack for 1 cycle -> frame_valid=0 and pix_ready=1 next cycle, pix_count=0.
- Random pix_valid gaps (about 50%) over a frame of 0xA0+i -> identical final image to the gapless case; frame_valid asserts exactly once.
- Assert rst after 7 pixels, then stream a full frame of 0x33 -> all 16 elements read 0x33; pix_count=16; no stale pixels remain.
- frame_ack held high continuously across two back-to-back frames -> each frame shows frame_valid for exactly 1 cycle; second frame content correct.
- IMG_SOF_CHECK_EN defined: send 6 pixels, then pixel 0x77 with pix_sof=1, then 15 more -> image_out[0][0]=0x77, frame completes after 16 post-SOF pixels, sof_err=1 and it stays 1 until rst.

Source files
------------

// File: rtl/frame_assembler.sv
// frame_assembler: gathers a row-major pixel stream into a registered N*N frame and holds it until acked.
// Optional macro IMG_SOF_CHECK_EN: pix_sof realigns the fill to pixel (0,0) and misalignment sets sof_err.
module frame_assembler #(
   parameter int N  = 32,
   parameter int PW = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [PW-1:0]                    pix_in,
   input  logic                             pix_valid,
   input  logic                             pix_sof,
   output logic                             pix_ready,
   output logic [N-1:0][N-1:0][PW-1:0]      image_out,
   output logic                             frame_valid,
   input  logic                             frame_ack,
   output logic [$clog2(N*N+1)-1:0]         pix_count,
   output logic                             sof_err
);

   localparam int RW = $clog2(N);
   localparam int CW = $clog2(N*N+1);

   typedef enum logic {FILL, FULL} state_t;

   state_t                        state_q;
   logic [RW-1:0]                 row_q;
   logic [RW-1:0]                 col_q;
   logic [CW-1:0]                 count_q;
   logic                          frameValid_q;
   logic [N-1:0][N-1:0][PW-1:0]   image_q;
`ifdef IMG_SOF_CHECK_EN
   logic                          sofErr_q;
`else
   logic                          unusedSof;
`endif

   // Frame state machine; image_q is never cleared on ack, new pixels simply overwrite it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FILL;
         row_q        <= '0;
         col_q        <= '0;
         count_q      <= '0;
         frameValid_q <= 1'b0;
         image_q      <= '0;
`ifdef IMG_SOF_CHECK_EN
         sofErr_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            FILL: begin
               if (pix_valid) begin
`ifdef IMG_SOF_CHECK_EN
                  if (pix_sof) begin
                     image_q[0][0] <= pix_in;
                     row_q         <= '0;
                     col_q         <= RW'(1);
                     count_q       <= CW'(1);
                     if (count_q != '0) sofErr_q <= 1'b1;
                  end else begin
                     if (count_q == '0) sofErr_q <= 1'b1;
`else
                  begin
`endif
                     image_q[row_q][col_q] <= pix_in;
                     count_q               <= count_q + 1'b1;
                     if (col_q == RW'(N-1)) begin
                        col_q <= '0;
                        if (row_q == RW'(N-1)) begin
                           row_q        <= '0;
                           state_q      <= FULL;
                           frameValid_q <= 1'b1;
                        end else begin
                           row_q <= row_q + 1'b1;
                        end
                     end else begin
                        col_q <= col_q + 1'b1;
                     end
                  end
               end
            end
            FULL: begin
               if (frame_ack) begin
                  state_q      <= FILL;
                  frameValid_q <= 1'b0;
                  row_q        <= '0;
                  col_q        <= '0;
                  count_q      <= '0;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign pix_ready   = (state_q == FILL);
   assign image_out   = image_q;
   assign frame_valid = frameValid_q;
   assign pix_count   = count_q;
`ifdef IMG_SOF_CHECK_EN
   assign sof_err     = sofErr_q;
`else
   assign unusedSof   = pix_sof;
   assign sof_err     = 1'b0;
`endif

endmodule

// File: tb/tb_frame_assembler.sv
// tb_frame_assembler: directed checks of fill, hold, ack, reset and gap handling with N=4.
// Define IMG_SOF_CHECK_EN to also exercise the start-of-frame realignment path.
module tb_frame_assembler;

   localparam int N  = 4;
   localparam int PW = 8;

   logic                        clk;
   logic                        rst;
   logic [PW-1:0]               pixIn;
   logic                        pixValid;
   logic                        pixSof;
   logic                        pixReady;
   logic [N-1:0][N-1:0][PW-1:0] imageOut;
   logic                        frameValid;
   logic                        frameAck;
   logic [4:0]                  pixCount;
   logic                        sofErr;

   int checks = 0;
   int errors = 0;

   frame_assembler #(.N(N), .PW(PW)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_in     (pixIn),
      .pix_valid  (pixValid),
      .pix_sof    (pixSof),
      .pix_ready  (pixReady),
      .image_out  (imageOut),
      .frame_valid(frameValid),
      .frame_ack  (frameAck),
      .pix_count  (pixCount),
      .sof_err    (sofErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drives one cycle of inputs, then samples 1 time unit after the rising edge.
   task automatic applyStimulus(input logic v, input logic [7:0] p, input logic s, input logic a);
      pixValid = v;
      pixIn    = p;
      pixSof   = s;
      frameAck = a;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   int idx;
   int cycles;
   int rises;
   int fvHigh;
   logic prevFv;
   logic v;

   initial begin
      rst = 1'b1; pixIn = '0; pixValid = 1'b0; pixSof = 1'b0; frameAck = 1'b0;
      doReset();
      checkOutput("rstReady", pixReady, 1);
      checkOutput("rstFv", frameValid, 0);
      checkOutput("rstCount", pixCount, 0);
      checkOutput("rstImg00", imageOut[0][0], 0);
      checkOutput("rstImg33", imageOut[3][3], 0);
      checkOutput("rstSofErr", sofErr, 0);

      // Gapless frame 0x01..0x10
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 8'(i + 1), i == 0, 1'b0);
         if (i == 14) checkOutput("fvBeforeLast", frameValid, 0);
      end
      checkOutput("fvAfterLast", frameValid, 1);
      checkOutput("img00", imageOut[0][0], 8'h01);
      checkOutput("img10", imageOut[1][0], 8'h05);
      checkOutput("img33", imageOut[3][3], 8'h10);
      checkOutput("fullCount", pixCount, 16);
      checkOutput("fullReady", pixReady, 0);

      // Hold with traffic offered, then a single ack cycle
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
         checkOutput("holdFv", frameValid, 1);
         checkOutput("holdCount", pixCount, 16);
      end
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            checkOutput("holdImg", imageOut[r][c], 32'(r * N + c + 1));
      applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1);
      checkOutput("ackFv", frameValid, 0);
      checkOutput("ackReady", pixReady, 1);
      checkOutput("ackCount", pixCount, 0);
      checkOutput("ackImgKept", imageOut[0][0], 8'h01);
      applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
      checkOutput("postAckCount", pixCount, 1);
      checkOutput("postAckImg", imageOut[0][0], 8'hFF);

      // Random gaps over a frame of 0xA0+i
      doReset();
      idx = 0; cycles = 0; rises = 0; prevFv = frameValid;
      while (idx < 16 && cycles < 200) begin
         v = 1'($urandom_range(0, 1));
         applyStimulus(v, 8'(8'hA0 + idx), idx == 0, 1'b0);
         if (v) idx++;
         cycles++;
         if (frameValid && !prevFv) rises++;
         prevFv = frameValid;
         checkOutput("gapFv", frameValid, (idx == 16) ? 1 : 0);
      end
      if (idx < 16) checkOutput("gapTimeout", idx, 16);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 8'h00, 1'b0, 1'b0);
         if (frameValid && !prevFv) rises++;
         prevFv = frameValid;
      end
      checkOutput("gapRises", rises, 1);
      checkOutput("gapCount", pixCount, 16);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            checkOutput("gapImg", imageOut[r][c], 32'(8'hA0 + r * N + c));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

      // Reset after 7 pixels, then a full frame of 0x33
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h50 + i), i == 0, 1'b0);
      checkOutput("partCount", pixCount, 7);
      doReset();
      checkOutput("midRstCount", pixCount, 0);
      checkOutput("midRstImg", imageOut[1][2], 0);
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'h33, i == 0, 1'b0);
      checkOutput("rstFrameFv", frameValid, 1);
      checkOutput("rstFrameCount", pixCount, 16);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            checkOutput("rstFrameImg", imageOut[r][c], 8'h33);

      // Back-to-back frames with ack held high
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("b2bStartFv", frameValid, 0);
      fvHigh = 0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 8'(8'h60 + i), i == 0, 1'b1);
         if (frameValid) fvHigh++;
      end
      checkOutput("b2bFv1", frameValid, 1);
      checkOutput("b2bImg1", imageOut[3][3], 8'h6F);
      applyStimulus(1'b1, 8'h80, 1'b1, 1'b1);
      if (frameValid) fvHigh++;
      checkOutput("b2bAckFv", frameValid, 0);
      checkOutput("b2bAckCount", pixCount, 0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 8'(8'h80 + i), i == 0, 1'b1);
         if (frameValid) fvHigh++;
      end
      checkOutput("b2bFv2", frameValid, 1);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            checkOutput("b2bImg2", imageOut[r][c], 32'(8'h80 + r * N + c));
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
      if (frameValid) fvHigh++;
      checkOutput("b2bEndFv", frameValid, 0);
      checkOutput("b2bFvCycles", fvHigh, 2);
      checkOutput("noSofErr", sofErr, 0);

`ifdef IMG_SOF_CHECK_EN
      // Mid-frame SOF realigns to (0,0) and sets a sticky error
      doReset();
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h40 + i), i == 0, 1'b0);
      checkOutput("sofPreErr", sofErr, 0);
      applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
      checkOutput("sofCount", pixCount, 1);
      checkOutput("sofErrSet", sofErr, 1);
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
         if (i == 13) checkOutput("sofFvEarly", frameValid, 0);
      end
      checkOutput("sofFv", frameValid, 1);
      checkOutput("sofFullCount", pixCount, 16);
      checkOutput("sofImg00", imageOut[0][0], 8'h77);
      checkOutput("sofImg01", imageOut[0][1], 8'h90);
      checkOutput("sofImg33", imageOut[3][3], 8'h9E);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
      checkOutput("sofErrSticky", sofErr, 1);
      doReset();
      checkOutput("sofErrCleared", sofErr, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
